// File: rtl/strobe_pkg.sv
// Shared definitions for the toggle-flag strobe receiver: FSM encodings and
// the minimum synchronizer depth.
package strobe_pkg;
  localparam int MIN_DELAY = 2;

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_WAIT_SPACE = 1'b1
  } state_e;
endpackage

// File: rtl/strobe_rx_fifo.sv
// Synchronous FIFO for strobe_rx. The head word is read from the storage
// registers, so it is valid in the same cycle the count goes non-zero.
module strobe_rx_fifo
  import strobe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign head  = mem_q[rd_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/strobe_rx.sv
// Receive end of the toggle-flag strobe crossing. Define STROBE_RX_ACK_EN to
// generate ack_toggle and the WAIT_SPACE backpressure path; otherwise words
// arriving at a full FIFO are dropped and flagged in overflow.
module strobe_rx
  import strobe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DELAY = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_toggle,
  input  logic [WIDTH-1:0]       req_data,
  output logic                   ack_toggle,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   protocol_err
);
  localparam int SYNC_W = (DELAY < MIN_DELAY) ? MIN_DELAY : DELAY;

  logic [SYNC_W-1:0] sync_q;
  logic              seen_q;
  logic              evt;
  logic              full, empty, pop, push, can_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      seen_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_W-2:0], req_toggle};
      seen_q <= sync_q[SYNC_W-1];
    end
  end

  assign evt       = sync_q[SYNC_W-1] ^ seen_q;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign can_write = !full || pop;

  strobe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .head      (out_data)
  );

`ifdef STROBE_RX_ACK_EN
  state_e state_q;
  logic   ack_q, perr_q;

  // In WAIT_SPACE the sender still holds req_data, so it is pushed the first
  // cycle space appears.
  assign push = can_write && ((state_q == ST_IDLE && evt) || state_q == ST_WAIT_SPACE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt) begin
            if (can_write) ack_q   <= ~ack_q;
            else           state_q <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (evt) perr_q <= 1'b1;
          if (can_write) begin
            ack_q   <= ~ack_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_toggle   = ack_q;
  assign protocol_err = perr_q;
  assign overflow     = 1'b0;
`else
  logic ovf_q;

  assign push = evt && can_write;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (evt && !can_write) ovf_q <= 1'b1;
  end

  assign ack_toggle   = 1'b0;
  assign protocol_err = 1'b0;
  assign overflow     = ovf_q;
`endif
endmodule

// File: doc/strobe_rx.md
# strobe_rx

Receive end of the toggle-flag strobe crossing. It runs entirely in the destination clock domain. It synchronizes the sender's asynchronous `req_toggle`, detects each flip as one transfer, captures the held `req_data` bus into a small FIFO, and presents the words downstream on a valid/ready interface. With acknowledge enabled, it returns an `ack_toggle` so the sender can hold off until each word has been taken.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `DELAY`, 2: synchronizer stages on `req_toggle`; must be ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: destination-domain clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_toggle`  in  1: asynchronous request flag; each flip is one transfer.
- `req_data`  in  WIDTH: asynchronous data; the sender holds it stable from the flip until the acknowledge, or for ≥ DELAY+2 `clk` cycles when acknowledge is disabled.
- `ack_toggle`  out  1: flips once per captured word.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: downstream accepts the head word.
- `out_data`  out  WIDTH: FIFO head word.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky; a word was dropped.
- `protocol_err`  out  1: sticky; a second flip arrived while the previous transfer was still unacknowledged.

## Operation
- Synchronizer `sync[DELAY-1:0]` shifts in `req_toggle` every cycle. Register `seen` holds the last value of `sync[DELAY-1]`. `event = sync[DELAY-1] ^ seen`; `seen` updates every cycle.
- `can_write = !full || (out_valid && out_ready)`. A pop and a push in the same cycle are legal when the FIFO is full.
- FSM states:
  - IDLE, on `event`: if `can_write`, push `req_data`, flip `ack_toggle`, stay in IDLE. Otherwise go to WAIT_SPACE.
  - WAIT_SPACE: each cycle, when `can_write`, push `req_data`, flip `ack_toggle`, return to IDLE. The data is still held because the sender is waiting for the acknowledge.
  - An `event` while in WAIT_SPACE sets `protocol_err` and is otherwise ignored.
- Pop when `out_valid && out_ready`. `out_data` is the registered head word and is valid whenever `out_valid` is high.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` = write count minus read count, range 0..DEPTH.
- Reset values: `sync` = 0, `seen` = 0, `ack_toggle` = 0, `out_valid` = 0, `out_data` = 0, `level` = 0, `overflow` = 0, `protocol_err` = 0, state = IDLE, pointers = 0.
- `rst` applied mid-transfer discards the FIFO contents and any pending WAIT_SPACE word.
- Sender and receiver are reset together. If `req_toggle` is 1 when `rst` releases, exactly one event is produced.

## Timing
- Take `req_toggle` flipping between edge 0 and edge 1.
  - `sync[DELAY-1]` changes at edge DELAY.
  - When space is available, the push happens at edge DELAY+1.
  - `out_valid`, `out_data`, `level` and `ack_toggle` all update at edge DELAY+1.
- Minimum spacing between sender flips: DELAY+1 `clk` cycles. Closer flips may merge.
- A pop of the only entry takes `out_valid` low at the next edge. There is no combinational path from `out_ready` to `out_valid`.
- WAIT_SPACE exit: the push happens in the same cycle that `can_write` first becomes true.

## Configuration
- Macro: `STROBE_RX_ACK_EN`.
- Defined: `ack_toggle` is generated, the WAIT_SPACE backpressure path is active, `overflow` stays 0.
- Undefined:
  - `ack_toggle` is tied 0 and WAIT_SPACE is removed.
  - An event with `can_write` false drops the word and sets `overflow`.
  - `protocol_err` is tied 0.

## Structure
- Shared package `strobe_pkg`: FSM state encodings (`ST_IDLE`, `ST_WAIT_SPACE`) and the minimum-DELAY constant.
- One sub-module, `strobe_rx_fifo`: a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level/head. The FSM and synchronizer stay in `strobe_rx`.

## Test plan
- Single transfer: flip `req_toggle` with `req_data`=0xA5, `out_ready`=1 → `out_valid` high exactly at edge DELAY+1 with `out_data`=0xA5, `ack_toggle` 0→1, `level` back to 0 one cycle later.
- Fill: `out_ready`=0, send 0x01..0x04 spaced DELAY+2 apart → `level`=4, four acks. A 5th flip (0x05) → no ack, FSM in WAIT_SPACE. Raise `out_ready` for one cycle → 0x01 popped and 0x05 pushed in the same cycle, `level` stays 4, ack flips.
- Order and wrap: stream 10 words 0x10..0x19 with random `out_ready` → all 10 emerged in order, 10 ack flips, `overflow`=0.
- Protocol error (ACK_EN): FIFO full, hold in WAIT_SPACE, flip `req_toggle` again → `protocol_err`=1 and sticky until `rst`.
- No ACK_EN: FIFO full, flip with 0x55 → `overflow`=1, `level`=4, 0x55 never appears; `ack_toggle` constant 0.
- Reset mid-operation: `level`=3, assert `rst` for 1 cycle → all outputs at reset values next edge; a subsequent transfer 0x3C is delivered normally.
